rx_2: RTL and testbench
=======================

# rx_2

UART receiver companion to the `tx_2` transmitter in the serial link block. It recovers 8N1 frames from the asynchronous `rx` line using the shared 16x-oversample tick `boud_in`. Frames are MSB-first to match the transmitter. Each received byte is presented on `rx_data` with a one-cycle `rx_valid` strobe, and a bad stop bit raises a one-cycle `frame_err` strobe.

## Interface
- `DATA_BITS`, default 8: data bits per frame; the bit counter width is `$clog2(DATA_BITS+1)`.
- `OVERSAMPLE`, default 16: ticks per bit, fixed at 16; the tick counter is 4 bits.
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst`, input, 1: reset, synchronous and active-low. Holding it low for one rising edge resets the block.
- `boud_in`, input, 1: oversample tick, one `clk` cycle wide, at 16x the baud rate.
- `en`, input, 1: receive enable. It gates start-bit detection only.
- `rx`, input, 1: asynchronous serial line. The line idles high.
- `rx_data`, output, `DATA_BITS`: last good byte. It holds its value until the next good frame.
- `rx_valid`, output, 1: one-cycle pulse when `rx_data` is updated.
- `frame_err`, output, 1: one-cycle pulse when the stop bit is sampled low.
- `busy`, output, 1: high in every state except IDLE.

## Operation
- Input synchronizer:
  - `rx` passes through 2 flops to produce `rx_s`. Both flops reset to 1.
  - All decisions use `rx_s` only.
- Registers:
  - `state` (IDLE, START, DATA, STOP).
  - 4-bit `tick_cnt`.
  - Bit counter `bit_cnt`.
  - Shift register `shreg`.
  - `armed` flag.
- IDLE:
  - `armed` is set whenever `rx_s`=1.
  - If `en`=1, `armed`=1 and `rx_s`=0: go to START and clear `tick_cnt`.
  - This check does not wait for a tick; `rx_s` is checked every `clk`.
- START:
  - `tick_cnt` increments on each `boud_in`.
  - On the tick where `tick_cnt`==7 (mid start bit):
    - If `rx_s`=0: go to DATA, clear `tick_cnt` and `bit_cnt`.
    - If `rx_s`=1: false start; return to IDLE with no output.
- DATA:
  - On the tick where `tick_cnt`==15 (mid data bit):
    - Update `shreg` <= {`shreg`[DATA_BITS-2:0], `rx_s`}. The first received bit lands in the MSB.
    - Increment `bit_cnt` and clear `tick_cnt`.
  - When the DATA_BITS-th bit is sampled, go to STOP.
- STOP:
  - On the tick where `tick_cnt`==15:
    - If `rx_s`=1: `rx_data` <= `shreg`, pulse `rx_valid`, go to IDLE.
    - If `rx_s`=0: pulse `frame_err`, leave `rx_data` unchanged, clear `armed`, go to IDLE.
  - After a framing error, no new start is accepted until `rx_s` returns high. This covers break conditions.
- `en` behaviour: deasserting `en` mid-frame does not abort the frame; the frame completes normally.
- Tick counting: `tick_cnt` only advances on `boud_in`. Without ticks the FSM holds its state.
- `rx_valid` and `frame_err` are mutually exclusive and never asserted in consecutive cycles for the same frame.

## Timing
- Reset values:
  - `rx_data`=0, `rx_valid`=0, `frame_err`=0, `busy`=0.
  - `state`=IDLE, `tick_cnt`=0, `bit_cnt`=0, `shreg`=0, `armed`=0.
  - Synchronizer flops = 1.
- Reset mid-frame: the frame is abandoned. No `rx_valid` or `frame_err` is produced for it.
- Synchronizer latency: 2 `clk` cycles from `rx` to `rx_s`.
- Start detection: START is entered 1 `clk` after `rx_s` falls. Sampling points are at ticks 8, 24, 40, … after entry, i.e. mid-bit.
- Output latency: `rx_valid`/`frame_err` are registered, high in the `clk` cycle after the stop-bit sampling tick, for exactly 1 cycle.
- `rx_data` changes on the same edge that `rx_valid` rises.
- Back-to-back frames:
  - The block returns to IDLE at mid stop bit.
  - A start edge arriving 8 ticks later is accepted.
  - No dead time beyond this is required.
- Frame length: one full frame is 8 + 16×DATA_BITS + 16 ticks to the stop sample, i.e. 152 ticks for 8 bits.

## Test plan
- Frame with bits 1,0,1,0,0,1,0,1 (MSB first, stop=1), `en`=1 → `rx_data`=0xA5, `rx_valid` high for 1 cycle, `frame_err`=0, `busy` falls with `rx_valid`.
- Back-to-back 0x00 then 0xFF with no idle gap → two `rx_valid` pulses, data 0x00 then 0xFF.
- 4-tick low glitch on an idle line → START entered, then return to IDLE at tick 8 with no pulses and `rx_data` unchanged.
- Frame 0x3C with stop bit=0 and the line held low 40 ticks before rising → one `frame_err` pulse, no `rx_valid`, `rx_data` keeps its prior value.
  - No new frame starts until the line goes high.
  - A following 0x81 frame is received correctly.
- `en`=0 during a full frame → `busy` stays 0 and no pulses occur.
  - `en` dropped mid-frame of 0x5A → `rx_valid` and 0x5A still delivered.
- `rst` low at bit 4 of a frame → all outputs and state return to reset values the next cycle. Remaining bits are ignored until the line idles high and a new start arrives.

Source files
------------

// File: rtl/rx_2_if.sv
// rx_2_if: signal bundle between the UART receiver and its surroundings.
//
// Handshake: rx_valid and frame_err are single-cycle strobes with no ready
// or backpressure. The consumer must capture rx_data in the cycle rx_valid is
// high. rx_data itself is held until the next good frame, so late readers
// still see the last good byte. At most one of rx_valid and frame_err is high
// in any cycle.
//
// Signals:
//   boud_in   : 16x oversample tick, one clk wide (towards receiver)
//   en        : receive enable, gates start detection only (towards receiver)
//   rx        : asynchronous serial line, idles high (towards receiver)
//   rx_data   : last good byte (from receiver)
//   rx_valid  : one-cycle strobe when rx_data updates (from receiver)
//   frame_err : one-cycle strobe on a low stop bit (from receiver)
//   busy      : receiver is not idle (from receiver)
interface rx_2_if #(
  parameter int DATA_BITS = 8
);
  logic                 boud_in;
  logic                 en;
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 busy;

  // master: the side that drives the line and consumes received bytes
  modport master (
    output boud_in, en, rx,
    input  rx_data, rx_valid, frame_err, busy
  );

  // slave: the receiver itself
  modport slave (
    input  boud_in, en, rx,
    output rx_data, rx_valid, frame_err, busy
  );
endinterface

// File: rtl/rx_2.sv
// rx_2: UART receiver for 8N1 frames, MSB first, using a shared 16x
// oversample tick. Each good byte is presented on rx_data with a one-cycle
// rx_valid strobe; a low stop bit gives a one-cycle frame_err strobe.
//
// Ports:
//   clk         : system clock, rising edge
//   rst         : synchronous active-low reset
//   bus         : rx_2_if slave modport (boud_in, en, rx in;
//                 rx_data, rx_valid, frame_err, busy out)
//   o_dbg_state : current FSM state (IDLE=0, START=1, DATA=2, STOP=3)
module rx_2 #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic        clk,
  input  logic        rst,
  rx_2_if.slave       bus,
  output logic [1:0]  o_dbg_state
);

  localparam int BW = $clog2(DATA_BITS + 1);
  // Tick counter value at which the start bit is checked (its middle) and
  // at which data/stop bits are sampled (one full bit after the last sample).
  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Registers
  logic                 r_rx_meta;
  logic                 r_rx_s;
  state_t               r_state;
  logic [3:0]           r_tick_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shreg;
  logic                 r_armed;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;

  // Next-state values
  state_t               w_state_nxt;
  logic [3:0]           w_tick_nxt;
  logic [BW-1:0]        w_bit_nxt;
  logic [DATA_BITS-1:0] w_shreg_nxt;
  logic                 w_armed_nxt;
  logic [DATA_BITS-1:0] w_rx_data_nxt;
  logic                 w_rx_valid_nxt;
  logic                 w_frame_err_nxt;

  // State register, synchronizer and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_meta   <= 1'b1;
      r_rx_s      <= 1'b1;
      r_state     <= S_IDLE;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shreg     <= '0;
      r_armed     <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_meta   <= bus.rx;
      r_rx_s      <= r_rx_meta;
      r_state     <= w_state_nxt;
      r_tick_cnt  <= w_tick_nxt;
      r_bit_cnt   <= w_bit_nxt;
      r_shreg     <= w_shreg_nxt;
      r_armed     <= w_armed_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  // Next-state and output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_tick_nxt      = r_tick_cnt;
    w_bit_nxt       = r_bit_cnt;
    w_shreg_nxt     = r_shreg;
    w_armed_nxt     = r_armed;
    w_rx_data_nxt   = r_rx_data;
    w_rx_valid_nxt  = 1'b0;
    w_frame_err_nxt = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        // armed blocks a new start after a framing error (or reset) until
        // the line has been seen high again, so a break is not mistaken for
        // a stream of start bits.
        if (r_rx_s) begin
          w_armed_nxt = 1'b1;
        end
        // Start detection runs every clk, not only on ticks.
        if (bus.en && r_armed && !r_rx_s) begin
          w_state_nxt = S_START;
          w_tick_nxt  = '0;
        end
      end

      S_START: begin
        if (bus.boud_in) begin
          if (r_tick_cnt == MID_TICK) begin
            if (!r_rx_s) begin
              w_state_nxt = S_DATA;
              w_tick_nxt  = '0;
              w_bit_nxt   = '0;
            end else begin
              // Line went back high before mid start bit: a glitch.
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + 4'd1;
          end
        end
      end

      S_DATA: begin
        if (bus.boud_in) begin
          if (r_tick_cnt == LAST_TICK) begin
            // First received bit ends up in the MSB.
            w_shreg_nxt = {r_shreg[DATA_BITS-2:0], r_rx_s};
            w_bit_nxt   = r_bit_cnt + BW'(1);
            w_tick_nxt  = '0;
            if (r_bit_cnt == LAST_BIT) begin
              w_state_nxt = S_STOP;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + 4'd1;
          end
        end
      end

      S_STOP: begin
        if (bus.boud_in) begin
          if (r_tick_cnt == LAST_TICK) begin
            if (r_rx_s) begin
              w_rx_data_nxt  = r_shreg;
              w_rx_valid_nxt = 1'b1;
            end else begin
              w_frame_err_nxt = 1'b1;
              w_armed_nxt     = 1'b0;
            end
            // Leaving at mid stop bit leaves half a bit of slack for the
            // next start edge.
            w_state_nxt = S_IDLE;
          end else begin
            w_tick_nxt = r_tick_cnt + 4'd1;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.rx_data   = r_rx_data;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = (r_state != S_IDLE);
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_rx_2.sv
// tb_rx_2: directed and randomized frames driven onto the serial line,
// with received strobes compared against an expected-event queue.
module tb_rx_2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  rx_2_if #(.DATA_BITS(8)) bus ();

  rx_2 #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Oversample tick: one clk high every 4 clks, changed on the falling edge.
  initial begin
    bus.boud_in = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      bus.boud_in = 1'b1;
      @(negedge clk);
      bus.boud_in = 1'b0;
    end
  end

  // ---------------- scoreboard state ----------------
  int         n_vec  = 0;
  int         n_fail = 0;
  // Each entry: {frame_err, rx_data} expected when a strobe fires.
  logic [8:0] exp_q[$];
  logic [7:0] last_good = 8'h00;
  logic       busy_seen = 1'b0;
  logic       prev_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a good frame delivers its byte; a bad stop bit
  // reports an error while the held byte stays the last good one.
  task automatic expect_good(input logic [7:0] d);
    exp_q.push_back({1'b0, d});
    last_good = d;
  endtask

  task automatic expect_err();
    exp_q.push_back({1'b1, last_good});
  endtask

  // Monitor: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.busy) busy_seen = 1'b1;
      if (bus.rx_valid || bus.frame_err) begin
        chk("mutex", 32'(bus.rx_valid & bus.frame_err), 32'd0);
        chk("busy_fall", 32'(bus.busy), 32'd0);
        chk("busy_before", 32'(prev_busy), 32'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_event", 32'(exp_q.size()), 32'd1);
        end else begin
          chk("event", 32'({bus.frame_err, bus.rx_data}), 32'(exp_q.pop_front()));
        end
      end
      prev_busy = bus.busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!bus.boud_in) @(posedge clk);
    end
    #1;
  endtask

  task automatic drive(input logic v, input int ticks);
    bus.rx = v;
    wait_ticks(ticks);
  endtask

  // Start bit, 8 data bits MSB first, stop level held for stop_ticks,
  // line returned high. en is dropped at data bit index en_off (if >= 0).
  task automatic send_frame(input logic [7:0] d, input logic stop_v,
                            input int stop_ticks, input int en_off);
    drive(1'b0, 16);
    for (int i = 0; i < 8; i++) begin
      if (i == en_off) bus.en = 1'b0;
      drive(d[7-i], 16);
    end
    drive(stop_v, stop_ticks);
    bus.rx = 1'b1;
  endtask

  task automatic drain(input string tag);
    drive(1'b1, 12);
    chk(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] rd;
    logic       rok;
    logic [7:0] rst_byte;

    bus.rx = 1'b1;
    bus.en = 1'b1;
    rst    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rx_data", 32'(bus.rx_data), 32'd0);
    chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    drive(1'b1, 4);

    // Single frame 0xA5
    expect_good(8'hA5);
    send_frame(8'hA5, 1'b1, 16, -1);
    drain("drain_a5");

    // Back-to-back 0x00 then 0xFF, no idle gap
    expect_good(8'h00);
    expect_good(8'hFF);
    send_frame(8'h00, 1'b1, 16, -1);
    send_frame(8'hFF, 1'b1, 16, -1);
    drain("drain_b2b");

    // 4-tick glitch: START entered, then dropped without output
    busy_seen = 1'b0;
    drive(1'b0, 4);
    drive(1'b1, 16);
    chk("glitch_busy_seen", 32'(busy_seen), 32'd1);
    chk("glitch_busy_idle", 32'(bus.busy), 32'd0);
    chk("glitch_rx_data", 32'(bus.rx_data), 32'(last_good));
    drain("drain_glitch");

    // Framing error with line held low 40 ticks, then a good 0x81
    expect_err();
    send_frame(8'h3C, 1'b0, 40, -1);
    chk("ferr_rx_data_hold", 32'(bus.rx_data), 32'(last_good));
    chk("ferr_no_restart", 32'(bus.busy), 32'd0);
    drive(1'b1, 16);
    expect_good(8'h81);
    send_frame(8'h81, 1'b1, 16, -1);
    drain("drain_ferr");

    // en=0 for a whole frame: ignored entirely
    bus.en = 1'b0;
    busy_seen = 1'b0;
    send_frame(8'hC3, 1'b1, 16, -1);
    drive(1'b1, 8);
    chk("en_off_busy", 32'(busy_seen), 32'd0);
    bus.en = 1'b1;
    drain("drain_en_off");

    // en dropped mid-frame: frame still delivered
    expect_good(8'h5A);
    send_frame(8'h5A, 1'b1, 16, 3);
    bus.en = 1'b1;
    drain("drain_en_drop");

    // Randomized frames with occasional bad stop bits
    for (int k = 0; k < 10; k++) begin
      rd  = 8'($urandom_range(0, 255));
      rok = ($urandom_range(0, 3) != 0);
      if (rok) expect_good(rd);
      else     expect_err();
      send_frame(rd, rok, 16, -1);
      drive(1'b1, $urandom_range(2, 12));
    end
    drain("drain_random");

    // Reset in the middle of data bit index 4 of 0x0F; the frame is lost
    rst_byte = 8'h0F;
    drive(1'b0, 16);
    for (int i = 0; i < 4; i++) drive(rst_byte[7-i], 16);
    drive(rst_byte[3], 8);
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    last_good = 8'h00;
    chk("midrst_rx_data", 32'(bus.rx_data), 32'd0);
    chk("midrst_rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("midrst_frame_err", 32'(bus.frame_err), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_state", 32'(dbg_state), 32'd0);
    wait_ticks(7);
    for (int i = 5; i < 8; i++) drive(rst_byte[7-i], 16);
    drive(1'b1, 16);
    chk("midrst_no_output", 32'(bus.rx_data), 32'd0);
    drain("drain_midrst");
    expect_good(8'hE7);
    send_frame(8'hE7, 1'b1, 16, -1);
    drain("drain_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
